axi_lite_csr_slave: RTL and testbench
=====================================

# axi_lite_csr_slave

Parametrised AXI4-Lite control/status register slave, next generation of the accelerator's AXI-Lite control front end. Adds a full read channel, independent AW/W acceptance, byte strobes, a parametrised bank of configuration registers, and a sticky done/interrupt path. Sits between the host AXI-Lite interconnect and the matrix compute core. Drives the core's start pulse and configuration, and reports core status.

## Interface
- DATA_W, 32, data bus width; multiple of 8, at least 32.
- ADDR_W, 32, address bus width.
- NUM_CFG, 4, number of RW config registers, 1..62.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- s_axi_awaddr/awvalid/awready  in/in/out  ADDR_W/1/1  write address channel.
- s_axi_wdata/wstrb/wvalid/wready  in/in/in/out  DATA_W/DATA_W/8/1/1  write data channel.
- s_axi_bresp/bvalid/bready  out/out/in  2/1/1  write response channel.
- s_axi_araddr/arvalid/arready  in/in/out  ADDR_W/1/1  read address channel.
- s_axi_rdata/rresp/rvalid/rready  out/out/out/in  DATA_W/2/1/1  read data channel.
- core_start  out  1  one-cycle start pulse to the core.
- core_busy  in  1  core running (level).
- core_done  in  1  core finished (one-cycle pulse).
- cfg_out  out  NUM_CFG*DATA_W  config registers; CFG[i] occupies bits [i*DATA_W +: DATA_W].
- irq  out  1  registered done_sticky & irq_en.

## Operation
- Decode uses word index = addr[ADDR_W-1:2]; addr[1:0] are ignored.
- Register map:
  - 0x00 CTRL: bit0 START (write-only, reads 0), bit1 IRQ_EN (RW).
  - 0x04 STATUS: bit0 BUSY (RO, live core_busy), bit1 DONE (sticky, W1C).
  - 0x08+4*i CFG[i], i < NUM_CFG, RW.
  - All other bits read 0.
- Write path:
  - Holding flags aw_full and w_full.
  - awready = !aw_full && !bvalid; wready = !w_full && !bvalid.
  - AW and W may arrive in any order or in the same cycle. Each is captured into its own holding register on handshake.
  - Commit cycle: aw_full && w_full && !bvalid. On that edge:
    - the write is applied under wstrb (per byte);
    - bvalid is set;
    - both flags are cleared.
  - bvalid is held until bready. While bvalid is high, awready and wready stay low.
- Unmapped write address: no state change, bresp=2'b10 (SLVERR). Otherwise bresp=2'b00.
- Write to STATUS: only bit1 with wstrb[0] set has any effect (W1C). This access returns OKAY.
- START:
  - A CTRL write with wstrb[0] set, wdata[0]=1 and core_busy=0 at the commit edge sets core_start for exactly the next cycle.
  - If core_busy=1 at that edge, START is ignored. bresp stays OKAY and IRQ_EN is still written.
- Read path:
  - arready = !rvalid.
  - On AR handshake, rdata/rresp are registered and rvalid is set on the same edge.
  - rvalid is held until rready.
  - Unmapped read: rdata=0, rresp=2'b10.
- DONE: set by core_done; cleared by W1C. A set and a clear on the same edge resolve to set.

## Timing
- Reset values:
  - All ready and valid outputs 0.
  - bresp=0, rresp=0, rdata=0.
  - core_start=0, irq=0, cfg_out=0.
  - IRQ_EN=0, DONE=0; holding flags cleared.
  - Ready outputs become 1 on the first cycle after rst deasserts.
- Write latency:
  - bvalid rises 1 cycle after the later of the AW and W handshakes.
  - The register update is visible on the same edge that bvalid rises.
  - Next write acceptance is possible in the cycle after bready&&bvalid.
- Read latency:
  - rvalid rises 1 cycle after the AR handshake.
  - With rready tied high, one read completes every 2 cycles.
- Read data is sampled at the AR handshake edge. A read and a write commit to the same register on the same edge return the old value.
- Read and write channels are fully independent. A read may complete while a write response is pending.
- core_start rises 1 cycle after the commit edge.
- irq rises 1 cycle after DONE becomes 1 (or after IRQ_EN is set while DONE=1).
- Reset mid-transaction drops all in-flight transactions. No response is issued for them.
- Outputs must not depend combinationally on valid/ready inputs.

## Structure
- Shared package axi_ctrl_pkg holds:
  - resp constants RESP_OKAY=2'b00 and RESP_SLVERR=2'b10;
  - register offset constants CTRL_OFS, STATUS_OFS, CFG_BASE;
  - CTRL/STATUS bit-index constants.
- One sub-module, axi_lite_csr_regfile: strobed register storage for CTRL/CFG, W1C/sticky DONE logic, and the read mux. Channel handshake logic stays in the top.

## Test plan
- Reset, then AW and W in the same cycle to 0x08 with data 0xDEADBEEF and wstrb 0xF -> bvalid rises 1 cycle later, bresp=0, cfg_out[31:0]=0xDEADBEEF. Read 0x08 -> rvalid 1 cycle after AR, rdata=0xDEADBEEF, rresp=0.
- W first, AW 3 cycles later, to 0x0C with data 0x11223344 and wstrb 0x5 -> CFG[1]=0x00220044. Hold bready low for 4 cycles -> bvalid stays high and awready/wready stay 0 throughout.
- Write 0x40 (unmapped) -> bresp=2'b10, cfg_out unchanged. Read 0x40 -> rdata=0, rresp=2'b10.
- Write CTRL=0x3 with core_busy=0 -> exactly one core_start cycle, IRQ_EN=1. Pulse core_done -> STATUS reads 0x2 and irq rises. Write STATUS=0x2 -> DONE=0, irq=0.
- Write CTRL=0x1 with core_busy=1 -> no core_start, bresp=0. core_done on the same edge as a W1C write -> DONE stays 1.
- Assert rst while bvalid=1 and rvalid=1 -> the next cycle has all valids 0, cfg_out=0, and readies 1 after rst deasserts.

Source files
------------

// File: rtl/axi_ctrl_pkg.sv
// Shared constants for the AXI-Lite control front end: response codes,
// register byte offsets, CTRL/STATUS bit positions and a decode helper.
package axi_ctrl_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [31:0] CTRL_OFS   = 32'h0000_0000;
    localparam logic [31:0] STATUS_OFS = 32'h0000_0004;
    localparam logic [31:0] CFG_BASE   = 32'h0000_0008;

    localparam int CTRL_START_BIT  = 0;
    localparam int CTRL_IRQ_EN_BIT = 1;
    localparam int STATUS_BUSY_BIT = 0;
    localparam int STATUS_DONE_BIT = 1;

    typedef enum logic [1:0] {
        SEL_NONE,
        SEL_CTRL,
        SEL_STATUS,
        SEL_CFG
    } reg_sel_e;

    // Byte offsets are decoded as 32-bit word indices.
    function automatic int word_index(input logic [31:0] ofs);
        return int'(ofs >> 2);
    endfunction

endpackage

// File: rtl/axi_lite_csr_regfile.sv
// Register storage for CTRL/STATUS/CFG with byte strobes, the sticky DONE
// flag, the start pulse, the registered interrupt and the read mux.
module axi_lite_csr_regfile
    import axi_ctrl_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int NUM_CFG = 4,
    localparam int IDX_W  = ADDR_W - 2,
    localparam int STRB_W = DATA_W / 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic [IDX_W-1:0]          wr_idx,
    input  logic [DATA_W-1:0]         wr_data,
    input  logic [STRB_W-1:0]         wr_strb,
    output logic                      wr_err,
    input  logic [IDX_W-1:0]          rd_idx,
    output logic [DATA_W-1:0]         rd_data,
    output logic                      rd_err,
    input  logic                      core_busy,
    input  logic                      core_done,
    output logic                      core_start,
    output logic                      irq,
    output logic [NUM_CFG*DATA_W-1:0] cfg_out
);

    logic                              irq_en_q;
    logic                              done_q;
    logic [NUM_CFG-1:0][DATA_W-1:0]    cfg_q;
    reg_sel_e                          wr_sel;
    reg_sel_e                          rd_sel;
    logic                              ctrl_wr;
    logic                              status_wr;

    function automatic reg_sel_e decode(input logic [IDX_W-1:0] idx);
        reg_sel_e sel;
        sel = SEL_NONE;
        if (idx == IDX_W'(word_index(CTRL_OFS)))
            sel = SEL_CTRL;
        else if (idx == IDX_W'(word_index(STATUS_OFS)))
            sel = SEL_STATUS;
        for (int i = 0; i < NUM_CFG; i++)
            if (idx == IDX_W'(word_index(CFG_BASE) + i))
                sel = SEL_CFG;
        return sel;
    endfunction

    assign wr_sel    = decode(wr_idx);
    assign rd_sel    = decode(rd_idx);
    assign wr_err    = (wr_sel == SEL_NONE);
    assign ctrl_wr   = wr_en && (wr_sel == SEL_CTRL) && wr_strb[0];
    assign status_wr = wr_en && (wr_sel == SEL_STATUS) && wr_strb[0];
    assign cfg_out   = cfg_q;

    // A core_done pulse wins over a simultaneous W1C clear of DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_en_q   <= 1'b0;
            done_q     <= 1'b0;
            cfg_q      <= '0;
            core_start <= 1'b0;
            irq        <= 1'b0;
        end else begin
            core_start <= ctrl_wr && wr_data[CTRL_START_BIT] && !core_busy;
            if (ctrl_wr)
                irq_en_q <= wr_data[CTRL_IRQ_EN_BIT];
            if (core_done)
                done_q <= 1'b1;
            else if (status_wr && wr_data[STATUS_DONE_BIT])
                done_q <= 1'b0;
            irq <= done_q & irq_en_q;
            for (int i = 0; i < NUM_CFG; i++)
                for (int b = 0; b < STRB_W; b++)
                    if (wr_en && wr_idx == IDX_W'(word_index(CFG_BASE) + i) && wr_strb[b])
                        cfg_q[i][8*b +: 8] <= wr_data[8*b +: 8];
        end
    end

    always_comb begin
        rd_data = '0;
        rd_err  = 1'b0;
        case (rd_sel)
            SEL_CTRL:   rd_data[CTRL_IRQ_EN_BIT] = irq_en_q;
            SEL_STATUS: begin
                rd_data[STATUS_BUSY_BIT] = core_busy;
                rd_data[STATUS_DONE_BIT] = done_q;
            end
            SEL_CFG: begin
                for (int i = 0; i < NUM_CFG; i++)
                    if (rd_idx == IDX_W'(word_index(CFG_BASE) + i))
                        rd_data = cfg_q[i];
            end
            default:    rd_err = 1'b1;
        endcase
    end

endmodule

// File: rtl/axi_lite_csr_slave.sv
// AXI4-Lite CSR slave: independent AW/W capture, single outstanding write
// response, registered read channel; register storage lives in the regfile.
module axi_lite_csr_slave
    import axi_ctrl_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int NUM_CFG = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [ADDR_W-1:0]         s_axi_awaddr,
    input  logic                      s_axi_awvalid,
    output logic                      s_axi_awready,
    input  logic [DATA_W-1:0]         s_axi_wdata,
    input  logic [DATA_W/8-1:0]       s_axi_wstrb,
    input  logic                      s_axi_wvalid,
    output logic                      s_axi_wready,
    output logic [1:0]                s_axi_bresp,
    output logic                      s_axi_bvalid,
    input  logic                      s_axi_bready,
    input  logic [ADDR_W-1:0]         s_axi_araddr,
    input  logic                      s_axi_arvalid,
    output logic                      s_axi_arready,
    output logic [DATA_W-1:0]         s_axi_rdata,
    output logic [1:0]                s_axi_rresp,
    output logic                      s_axi_rvalid,
    input  logic                      s_axi_rready,
    output logic                      core_start,
    input  logic                      core_busy,
    input  logic                      core_done,
    output logic [NUM_CFG*DATA_W-1:0] cfg_out,
    output logic                      irq
);

    localparam int IDX_W  = ADDR_W - 2;
    localparam int STRB_W = DATA_W / 8;

    logic                 ready_en_q;
    logic                 aw_full_q;
    logic [IDX_W-1:0]     aw_idx_q;
    logic                 w_full_q;
    logic [DATA_W-1:0]    w_data_q;
    logic [STRB_W-1:0]    w_strb_q;
    logic                 aw_hs;
    logic                 w_hs;
    logic                 ar_hs;
    logic                 commit;
    logic                 wr_err;
    logic [DATA_W-1:0]    rd_data;
    logic                 rd_err;
    logic                 unused_addr_bits;

    assign unused_addr_bits = &{1'b0, s_axi_awaddr[1:0], s_axi_araddr[1:0]};

    // Readies are gated by a registered flag so they stay low throughout reset.
    assign s_axi_awready = ready_en_q && !aw_full_q && !s_axi_bvalid;
    assign s_axi_wready  = ready_en_q && !w_full_q && !s_axi_bvalid;
    assign s_axi_arready = ready_en_q && !s_axi_rvalid;

    assign aw_hs  = s_axi_awvalid && s_axi_awready;
    assign w_hs   = s_axi_wvalid && s_axi_wready;
    assign ar_hs  = s_axi_arvalid && s_axi_arready;
    assign commit = aw_full_q && w_full_q && !s_axi_bvalid;

    always_ff @(posedge clk) begin
        if (rst) begin
            ready_en_q   <= 1'b0;
            aw_full_q    <= 1'b0;
            aw_idx_q     <= '0;
            w_full_q     <= 1'b0;
            w_data_q     <= '0;
            w_strb_q     <= '0;
            s_axi_bvalid <= 1'b0;
            s_axi_bresp  <= RESP_OKAY;
        end else begin
            ready_en_q <= 1'b1;
            if (aw_hs) begin
                aw_full_q <= 1'b1;
                aw_idx_q  <= s_axi_awaddr[ADDR_W-1:2];
            end
            if (w_hs) begin
                w_full_q <= 1'b1;
                w_data_q <= s_axi_wdata;
                w_strb_q <= s_axi_wstrb;
            end
            if (commit) begin
                aw_full_q    <= 1'b0;
                w_full_q     <= 1'b0;
                s_axi_bvalid <= 1'b1;
                s_axi_bresp  <= wr_err ? RESP_SLVERR : RESP_OKAY;
            end else if (s_axi_bvalid && s_axi_bready) begin
                s_axi_bvalid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_axi_rvalid <= 1'b0;
            s_axi_rdata  <= '0;
            s_axi_rresp  <= RESP_OKAY;
        end else if (ar_hs) begin
            s_axi_rvalid <= 1'b1;
            s_axi_rdata  <= rd_data;
            s_axi_rresp  <= rd_err ? RESP_SLVERR : RESP_OKAY;
        end else if (s_axi_rvalid && s_axi_rready) begin
            s_axi_rvalid <= 1'b0;
        end
    end

    axi_lite_csr_regfile #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .NUM_CFG (NUM_CFG)
    ) u_regfile (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (commit),
        .wr_idx     (aw_idx_q),
        .wr_data    (w_data_q),
        .wr_strb    (w_strb_q),
        .wr_err     (wr_err),
        .rd_idx     (s_axi_araddr[ADDR_W-1:2]),
        .rd_data    (rd_data),
        .rd_err     (rd_err),
        .core_busy  (core_busy),
        .core_done  (core_done),
        .core_start (core_start),
        .irq        (irq),
        .cfg_out    (cfg_out)
    );

endmodule

// File: tb/tb_axi_lite_csr_slave.sv
// Directed bench for axi_lite_csr_slave: inputs driven and outputs sampled on
// the falling edge, each check an immediate assertion against a fixed value.
module tb_axi_lite_csr_slave;

    logic         clk;
    logic         rst;
    logic [31:0]  s_axi_awaddr;
    logic         s_axi_awvalid;
    logic         s_axi_awready;
    logic [31:0]  s_axi_wdata;
    logic [3:0]   s_axi_wstrb;
    logic         s_axi_wvalid;
    logic         s_axi_wready;
    logic [1:0]   s_axi_bresp;
    logic         s_axi_bvalid;
    logic         s_axi_bready;
    logic [31:0]  s_axi_araddr;
    logic         s_axi_arvalid;
    logic         s_axi_arready;
    logic [31:0]  s_axi_rdata;
    logic [1:0]   s_axi_rresp;
    logic         s_axi_rvalid;
    logic         s_axi_rready;
    logic         core_start;
    logic         core_busy;
    logic         core_done;
    logic [127:0] cfg_out;
    logic         irq;

    int assert_count = 0;
    int fail_count   = 0;
    logic start_commit;
    logic start_after;

    axi_lite_csr_slave #(
        .DATA_W  (32),
        .ADDR_W  (32),
        .NUM_CFG (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axi_awaddr  (s_axi_awaddr),
        .s_axi_awvalid (s_axi_awvalid),
        .s_axi_awready (s_axi_awready),
        .s_axi_wdata   (s_axi_wdata),
        .s_axi_wstrb   (s_axi_wstrb),
        .s_axi_wvalid  (s_axi_wvalid),
        .s_axi_wready  (s_axi_wready),
        .s_axi_bresp   (s_axi_bresp),
        .s_axi_bvalid  (s_axi_bvalid),
        .s_axi_bready  (s_axi_bready),
        .s_axi_araddr  (s_axi_araddr),
        .s_axi_arvalid (s_axi_arvalid),
        .s_axi_arready (s_axi_arready),
        .s_axi_rdata   (s_axi_rdata),
        .s_axi_rresp   (s_axi_rresp),
        .s_axi_rvalid  (s_axi_rvalid),
        .s_axi_rready  (s_axi_rready),
        .core_start    (core_start),
        .core_busy     (core_busy),
        .core_done     (core_done),
        .cfg_out       (cfg_out),
        .irq           (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        assert_count++;
        assert (obs === exp) else begin
            fail_count++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // AW and W presented together; the commit edge follows the handshake edge.
    task automatic do_write(input string tag, input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input logic [1:0] exp_resp,
                            output logic start_at_commit, output logic start_next);
        s_axi_awaddr  = addr;
        s_axi_awvalid = 1'b1;
        s_axi_wdata   = data;
        s_axi_wstrb   = strb;
        s_axi_wvalid  = 1'b1;
        @(negedge clk);
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        check_output({tag, "_bvalid_pre"}, s_axi_bvalid, 1'b0);
        @(negedge clk);
        check_output({tag, "_bvalid"}, s_axi_bvalid, 1'b1);
        check_output({tag, "_bresp"}, s_axi_bresp, exp_resp);
        start_at_commit = core_start;
        s_axi_bready = 1'b1;
        @(negedge clk);
        s_axi_bready = 1'b0;
        start_next = core_start;
        check_output({tag, "_b_done"}, {s_axi_bvalid, s_axi_awready, s_axi_wready}, 3'b011);
    endtask

    task automatic do_read(input string tag, input logic [31:0] addr,
                           input logic [31:0] exp_data, input logic [1:0] exp_resp);
        s_axi_araddr  = addr;
        s_axi_arvalid = 1'b1;
        @(negedge clk);
        s_axi_arvalid = 1'b0;
        check_output({tag, "_rvalid"}, s_axi_rvalid, 1'b1);
        check_output({tag, "_rdata"}, s_axi_rdata, exp_data);
        check_output({tag, "_rresp"}, s_axi_rresp, exp_resp);
        s_axi_rready = 1'b1;
        @(negedge clk);
        s_axi_rready = 1'b0;
        check_output({tag, "_r_done"}, {s_axi_rvalid, s_axi_arready}, 2'b01);
    endtask

    initial begin
        rst = 1'b1;
        s_axi_awaddr = '0; s_axi_awvalid = 1'b0;
        s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wvalid = 1'b0;
        s_axi_bready = 1'b0;
        s_axi_araddr = '0; s_axi_arvalid = 1'b0; s_axi_rready = 1'b0;
        core_busy = 1'b0; core_done = 1'b0;

        // Reset values
        @(negedge clk);
        @(negedge clk);
        check_output("rst_readies", {s_axi_awready, s_axi_wready, s_axi_arready}, 3'b000);
        check_output("rst_valids", {s_axi_bvalid, s_axi_rvalid}, 2'b00);
        check_output("rst_resp_data", {s_axi_bresp, s_axi_rresp, s_axi_rdata}, 36'h0);
        check_output("rst_start_irq", {core_start, irq}, 2'b00);
        check_output("rst_cfg", cfg_out, 128'h0);
        rst = 1'b0;
        @(negedge clk);
        check_output("post_rst_readies", {s_axi_awready, s_axi_wready, s_axi_arready}, 3'b111);

        // AW and W together to CFG[0], then read back
        do_write("cfg0_wr", 32'h08, 32'hDEADBEEF, 4'hF, 2'b00, start_commit, start_after);
        check_output("cfg0_value", cfg_out[31:0], 32'hDEADBEEF);
        do_read("cfg0_rd", 32'h08, 32'hDEADBEEF, 2'b00);

        // W first, AW three cycles later, partial strobes, bready held low
        s_axi_wdata  = 32'h11223344;
        s_axi_wstrb  = 4'h5;
        s_axi_wvalid = 1'b1;
        @(negedge clk);
        s_axi_wvalid = 1'b0;
        check_output("wfirst_wready", {s_axi_wready, s_axi_awready}, 2'b01);
        @(negedge clk);
        @(negedge clk);
        s_axi_awaddr  = 32'h0C;
        s_axi_awvalid = 1'b1;
        @(negedge clk);
        s_axi_awvalid = 1'b0;
        check_output("wfirst_bvalid_pre", s_axi_bvalid, 1'b0);
        @(negedge clk);
        check_output("wfirst_bvalid", s_axi_bvalid, 1'b1);
        check_output("cfg1_value", cfg_out[63:32], 32'h00220044);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_output("bhold", {s_axi_bvalid, s_axi_awready, s_axi_wready}, 3'b100);
        end
        s_axi_bready = 1'b1;
        @(negedge clk);
        s_axi_bready = 1'b0;
        check_output("wfirst_b_done", {s_axi_bvalid, s_axi_awready, s_axi_wready}, 3'b011);

        // Unmapped address
        do_write("unmapped_wr", 32'h40, 32'hCAFEF00D, 4'hF, 2'b10, start_commit, start_after);
        check_output("unmapped_cfg", cfg_out, {32'h0, 32'h0, 32'h00220044, 32'hDEADBEEF});
        do_read("unmapped_rd", 32'h40, 32'h0, 2'b10);

        // START with IRQ_EN, done pulse, interrupt, W1C clear
        do_write("ctrl_start", 32'h00, 32'h3, 4'hF, 2'b00, start_commit, start_after);
        check_output("start_pulse", {start_commit, start_after}, 2'b10);
        do_read("ctrl_rd", 32'h00, 32'h2, 2'b00);
        core_done = 1'b1;
        @(negedge clk);
        core_done = 1'b0;
        @(negedge clk);
        check_output("irq_set", irq, 1'b1);
        do_read("status_done", 32'h04, 32'h2, 2'b00);
        do_write("status_w1c", 32'h04, 32'h2, 4'h1, 2'b00, start_commit, start_after);
        check_output("irq_clear", irq, 1'b0);
        do_read("status_clr", 32'h04, 32'h0, 2'b00);

        // START ignored while busy; IRQ_EN still written
        core_busy = 1'b1;
        do_write("ctrl_busy", 32'h00, 32'h1, 4'hF, 2'b00, start_commit, start_after);
        check_output("busy_no_start", {start_commit, start_after}, 2'b00);
        do_read("status_busy", 32'h04, 32'h1, 2'b00);
        do_read("ctrl_irq_off", 32'h00, 32'h0, 2'b00);
        core_busy = 1'b0;

        // core_done on the same edge as a W1C keeps DONE set
        core_done = 1'b1;
        @(negedge clk);
        core_done = 1'b0;
        s_axi_awaddr  = 32'h04;
        s_axi_awvalid = 1'b1;
        s_axi_wdata   = 32'h2;
        s_axi_wstrb   = 4'h1;
        s_axi_wvalid  = 1'b1;
        @(negedge clk);
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        core_done = 1'b1;
        @(negedge clk);
        core_done = 1'b0;
        check_output("w1c_race_bvalid", s_axi_bvalid, 1'b1);
        s_axi_bready = 1'b1;
        @(negedge clk);
        s_axi_bready = 1'b0;
        do_read("done_sticky", 32'h04, 32'h2, 2'b00);

        // Read completes while a write response is pending, then reset mid-flight
        s_axi_awaddr  = 32'h10;
        s_axi_awvalid = 1'b1;
        s_axi_wdata   = 32'hA5A5A5A5;
        s_axi_wstrb   = 4'hF;
        s_axi_wvalid  = 1'b1;
        @(negedge clk);
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        @(negedge clk);
        s_axi_araddr  = 32'h08;
        s_axi_arvalid = 1'b1;
        @(negedge clk);
        s_axi_arvalid = 1'b0;
        check_output("pending_both", {s_axi_bvalid, s_axi_rvalid}, 2'b11);
        check_output("pending_rdata", s_axi_rdata, 32'hDEADBEEF);
        check_output("cfg2_value", cfg_out[95:64], 32'hA5A5A5A5);
        rst = 1'b1;
        @(negedge clk);
        check_output("midrst_valids", {s_axi_bvalid, s_axi_rvalid}, 2'b00);
        check_output("midrst_readies", {s_axi_awready, s_axi_wready, s_axi_arready}, 3'b000);
        check_output("midrst_cfg", cfg_out, 128'h0);
        rst = 1'b0;
        @(negedge clk);
        check_output("midrst_recover", {s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid}, 5'b11100);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
